// File: rtl/adex_pkg.sv
// adex_pkg: FSM state type, default neuron constants and saturation helper for the AdEx neuron array.
package adex_pkg;
  typedef enum logic {IDLE, SWEEP} state_t;
  localparam int DEF_E_L = -4096;
  localparam int DEF_V_T = -1024;
  localparam int DEF_V_PEAK = 2048;
  localparam int DEF_V_RESET = -3072;
  localparam int DEF_B = 64;
  localparam int DEF_LEAK_SH = 4;
  localparam int DEF_CUR_SH = 2;
  localparam int DEF_DELTA_SH = 8;
  localparam int DEF_A_SH = 6;
  localparam int DEF_TAUW_SH = 5;
  localparam int DEF_EXP_CAP = 12;
  localparam int DEF_REF_STEPS = 2;
  function automatic logic signed [31:0] sat(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    return (x > hi) ? hi : (x < -hi - 32'sd1) ? -hi - 32'sd1 : x;
  endfunction
endpackage

// File: rtl/adex_neuron_mux_if.sv
// adex_neuron_mux_if: step, current-write, monitor and spike-report signals of the neuron array.
interface adex_neuron_mux_if #(parameter int N_NEURONS = 4, parameter int V_W = 16);
  localparam int AW = $clog2(N_NEURONS);
  logic step_i;
  logic i_we;
  logic [AW-1:0] i_addr;
  logic signed [V_W-1:0] i_data;
  logic [AW-1:0] mon_sel;
  logic signed [V_W-1:0] mon_v_o;
  logic signed [V_W-1:0] mon_w_o;
  logic [N_NEURONS-1:0] spike_o;
  logic spike_valid_o;
  logic busy_o;
  logic overrun_o;
  modport master (output step_i, i_we, i_addr, i_data, mon_sel,
                  input mon_v_o, mon_w_o, spike_o, spike_valid_o, busy_o, overrun_o);
  modport slave (input step_i, i_we, i_addr, i_data, mon_sel,
                 output mon_v_o, mon_w_o, spike_o, spike_valid_o, busy_o, overrun_o);
endinterface

// File: rtl/adex_update.sv
// adex_update: combinational forward-Euler step of one AdEx neuron.
// ADEX_REFRACTORY_EN adds a refractory counter that pins v and suppresses spikes while nonzero.
module adex_update import adex_pkg::*; #(
  parameter int V_W = 16,
  parameter int E_L = DEF_E_L,
  parameter int V_T = DEF_V_T,
  parameter int V_PEAK = DEF_V_PEAK,
  parameter int V_RESET = DEF_V_RESET,
  parameter int B = DEF_B,
  parameter int LEAK_SH = DEF_LEAK_SH,
  parameter int CUR_SH = DEF_CUR_SH,
  parameter int DELTA_SH = DEF_DELTA_SH,
  parameter int A_SH = DEF_A_SH,
  parameter int TAUW_SH = DEF_TAUW_SH,
  parameter int EXP_CAP = DEF_EXP_CAP
`ifdef ADEX_REFRACTORY_EN
  , parameter int REF_STEPS = DEF_REF_STEPS,
  parameter int CW = $clog2(REF_STEPS + 1)
`endif
) (
  input  logic signed [V_W-1:0] v,
  input  logic signed [V_W-1:0] w,
  input  logic signed [V_W-1:0] cur,
`ifdef ADEX_REFRACTORY_EN
  input  logic [CW-1:0] cnt,
  output logic [CW-1:0] cnt_n,
`endif
  output logic signed [V_W-1:0] v_n,
  output logic signed [V_W-1:0] w_n,
  output logic spike
);
  localparam int WW = V_W + 4;
  logic signed [WW-1:0] vx, wx, dlt, ex, vs, ws;
  logic signed [V_W-1:0] vi, wi, wb;
  logic [4:0] sh;
  logic hold;
  assign vx = WW'(v);
  assign wx = WW'(w);
  assign dlt = (vx - WW'(V_T)) >>> DELTA_SH;
  assign sh = (dlt > WW'(EXP_CAP)) ? 5'(EXP_CAP) : dlt[4:0];
  assign ex = (vx >= WW'(V_T)) ? (WW'(1) << sh) : WW'(0);
  assign vs = vx + ((WW'(E_L) - vx) >>> LEAK_SH) + ex + ((WW'(cur) - wx) >>> CUR_SH);
  assign ws = wx + ((((vx - WW'(E_L)) >>> A_SH) - wx) >>> TAUW_SH);
  assign vi = V_W'(sat(32'(vs), V_W));
  assign wi = V_W'(sat(32'(ws), V_W));
  assign wb = V_W'(sat(32'(wi) + B, V_W));
`ifdef ADEX_REFRACTORY_EN
  assign hold = cnt != '0;
  assign cnt_n = hold ? cnt - 1'b1 : spike ? CW'(REF_STEPS) : '0;
`else
  assign hold = 1'b0;
`endif
  // while refractory, adaptation still relaxes but no B kick is applied
  assign spike = !hold && vi >= V_W'(V_PEAK);
  assign v_n = (hold || spike) ? V_W'(V_RESET) : vi;
  assign w_n = spike ? wb : wi;
endmodule

// File: rtl/adex_neuron_mux.sv
// adex_neuron_mux: time-multiplexed AdEx neuron array, one neuron updated per cycle per sweep.
// ADEX_REFRACTORY_EN enables per-neuron refractory counters of REF_STEPS sweeps.
module adex_neuron_mux import adex_pkg::*; #(
  parameter int N_NEURONS = 4,
  parameter int V_W = 16,
  parameter int E_L = DEF_E_L,
  parameter int V_T = DEF_V_T,
  parameter int V_PEAK = DEF_V_PEAK,
  parameter int V_RESET = DEF_V_RESET,
  parameter int B = DEF_B,
  parameter int LEAK_SH = DEF_LEAK_SH,
  parameter int CUR_SH = DEF_CUR_SH,
  parameter int DELTA_SH = DEF_DELTA_SH,
  parameter int A_SH = DEF_A_SH,
  parameter int TAUW_SH = DEF_TAUW_SH,
  parameter int EXP_CAP = DEF_EXP_CAP
`ifdef ADEX_REFRACTORY_EN
  , parameter int REF_STEPS = DEF_REF_STEPS
`endif
) (
  input logic clk,
  input logic rst_n,
  adex_neuron_mux_if.slave bus
);
  localparam int AW = $clog2(N_NEURONS);
  state_t state, nxt;
  logic [AW-1:0] idx;
  logic signed [V_W-1:0] v_r [N_NEURONS];
  logic signed [V_W-1:0] w_r [N_NEURONS];
  logic signed [V_W-1:0] i_r [N_NEURONS];
  logic [N_NEURONS-1:0] acc, acc_n;
  logic signed [V_W-1:0] v_n, w_n;
  logic spike, start, last;
`ifdef ADEX_REFRACTORY_EN
  localparam int CW = $clog2(REF_STEPS + 1);
  logic [CW-1:0] c_r [N_NEURONS];
  logic [CW-1:0] c_n;
`endif
  adex_update #(
    .V_W(V_W), .E_L(E_L), .V_T(V_T), .V_PEAK(V_PEAK), .V_RESET(V_RESET), .B(B),
    .LEAK_SH(LEAK_SH), .CUR_SH(CUR_SH), .DELTA_SH(DELTA_SH), .A_SH(A_SH),
    .TAUW_SH(TAUW_SH), .EXP_CAP(EXP_CAP)
`ifdef ADEX_REFRACTORY_EN
    , .REF_STEPS(REF_STEPS), .CW(CW)
`endif
  ) u_update (
    .v(v_r[idx]),
    .w(w_r[idx]),
    .cur(i_r[idx]),
`ifdef ADEX_REFRACTORY_EN
    .cnt(c_r[idx]),
    .cnt_n(c_n),
`endif
    .v_n(v_n),
    .w_n(w_n),
    .spike(spike)
  );
  assign start = state == IDLE && bus.step_i;
  assign last = state == SWEEP && idx == AW'(N_NEURONS - 1);
  assign acc_n = acc | (N_NEURONS'(spike) << idx);
  assign bus.busy_o = state == SWEEP;
  always_comb begin
    nxt = state;
    nxt = start ? SWEEP : last ? IDLE : nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      acc <= '0;
      bus.spike_o <= '0;
      bus.spike_valid_o <= 1'b0;
      bus.overrun_o <= 1'b0;
      bus.mon_v_o <= '0;
      bus.mon_w_o <= '0;
      for (int k = 0; k < N_NEURONS; k++) begin
        v_r[k] <= V_W'(E_L);
        w_r[k] <= '0;
        i_r[k] <= '0;
`ifdef ADEX_REFRACTORY_EN
        c_r[k] <= '0;
`endif
      end
    end else begin
      state <= nxt;
      idx <= start ? '0 : (state == SWEEP) ? idx + 1'b1 : idx;
      acc <= start ? '0 : (state == SWEEP) ? acc_n : acc;
      bus.spike_valid_o <= last;
      if (last) bus.spike_o <= acc_n;
      bus.overrun_o <= bus.overrun_o | (bus.step_i && state == SWEEP);
      // the datapath reads i_r before this edge, so a same-cycle write is seen next sweep
      if (state == SWEEP) begin
        v_r[idx] <= v_n;
        w_r[idx] <= w_n;
`ifdef ADEX_REFRACTORY_EN
        c_r[idx] <= c_n;
`endif
      end
      if (bus.i_we) i_r[bus.i_addr] <= bus.i_data;
      bus.mon_v_o <= v_r[bus.mon_sel];
      bus.mon_w_o <= w_r[bus.mon_sel];
    end
  end
endmodule

// File: tb/tb_adex_neuron_mux.sv
// tb_adex_neuron_mux: directed + randomized checks of adex_neuron_mux against an integer sweep model.
module tb_adex_neuron_mux;
  localparam int N = 4;
  localparam int AW = 2;
  localparam int E_L = -4096, V_T = -1024, V_PEAK = 2048, V_RESET = -3072, B = 64;
`ifdef ADEX_REFRACTORY_EN
  localparam int REF = 2;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  adex_neuron_mux_if #(.N_NEURONS(N), .V_W(16)) bus ();
  adex_neuron_mux #(.N_NEURONS(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_cmp = 0;
  int n_err = 0;
  int mv[N], mw[N], mi[N], mr[N];

  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int x);
    return (x > 32767) ? 32767 : (x < -32768) ? -32768 : x;
  endfunction

  function automatic int expterm(input int v);
    int e;
    if (v < V_T) return 0;
    e = (v - V_T) / 256;
    if (e > 12) e = 12;
    return 1 << e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mv[k] = E_L; mw[k] = 0; mi[k] = 0; mr[k] = 0;
    end
  endtask

  task automatic model_sweep(output int sv);
    int v, w, vn, wn;
    sv = 0;
    for (int k = 0; k < N; k++) begin
      v = mv[k];
      w = mw[k];
      vn = clamp(v + ((E_L - v) >>> 4) + expterm(v) + ((mi[k] - w) >>> 2));
      wn = clamp(w + ((((v - E_L) >>> 6) - w) >>> 5));
      if (mr[k] > 0) begin
        mv[k] = V_RESET; mw[k] = wn; mr[k]--;
      end else if (vn >= V_PEAK) begin
        mv[k] = V_RESET; mw[k] = clamp(wn + B); sv |= 1 << k;
`ifdef ADEX_REFRACTORY_EN
        mr[k] = REF;
`endif
      end else begin
        mv[k] = vn; mw[k] = wn;
      end
    end
  endtask

  task automatic set_i(input int k, input int val);
    @(negedge clk);
    bus.i_we = 1'b1; bus.i_addr = AW'(k); bus.i_data = 16'(val);
    @(negedge clk);
    bus.i_we = 1'b0;
    mi[k] = val;
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      bus.mon_sel = AW'(k);
      @(negedge clk);
      chk($sformatf("%s v[%0d]", tag, k), bus.mon_v_o, mv[k]);
      chk($sformatf("%s w[%0d]", tag, k), bus.mon_w_o, mw[k]);
    end
  endtask

  // wr_k >= 0 writes I[wr_k] on the very edge that updates neuron wr_k; ovr_lat > 0 re-pulses step mid-sweep
  task automatic sweep(input string tag, input int wr_k, input int wr_val, input int ovr_lat);
    int lat, sv, extra;
    bit done;
    model_sweep(sv);
    @(negedge clk);
    bus.step_i = 1'b1;
    lat = 0;
    done = 1'b0;
    while (!done && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      bus.step_i = 1'b0;
      bus.i_we = 1'b0;
      if (lat == 1) chk({tag, " busy"}, bus.busy_o, 1);
      if (bus.spike_valid_o) done = 1'b1;
      else begin
        if (wr_k >= 0 && lat == wr_k + 1) begin
          bus.i_we = 1'b1; bus.i_addr = AW'(wr_k); bus.i_data = 16'(wr_val);
          mi[wr_k] = wr_val;
        end
        if (lat == ovr_lat) bus.step_i = 1'b1;
      end
    end
    chk({tag, " latency"}, lat, 5);
    chk({tag, " spike_o"}, bus.spike_o, sv);
    chk({tag, " busy_end"}, bus.busy_o, 0);
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.spike_valid_o) extra++;
    end
    chk({tag, " extra_valid"}, extra, 0);
  endtask

  initial begin
    int extra;
    bus.step_i = 1'b0; bus.i_we = 1'b0; bus.i_addr = '0; bus.i_data = '0; bus.mon_sel = '0;
    model_reset();
    #12;
    chk("rst busy", bus.busy_o, 0);
    chk("rst valid", bus.spike_valid_o, 0);
    chk("rst overrun", bus.overrun_o, 0);
    chk("rst spike", bus.spike_o, 0);
    chk("rst mon_v", bus.mon_v_o, 0);
    chk("rst mon_w", bus.mon_w_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_all("reset");
    sweep("zero", -1, 0, 0);
    check_all("zero");
    set_i(1, 400);
    sweep("i400", -1, 0, 0);
    @(negedge clk);
    bus.mon_sel = AW'(1);
    @(negedge clk);
    chk("i400 v1", bus.mon_v_o, -3996);
    chk("i400 w1", bus.mon_w_o, 0);
    check_all("i400");
    chk("pre overrun", bus.overrun_o, 0);
    sweep("ovr", -1, 0, 2);
    chk("overrun set", bus.overrun_o, 1);
    check_all("ovr");
    sweep("collide", 1, 1000, 0);
    check_all("collide");
    sweep("after_collide", -1, 0, 0);
    check_all("after_collide");
    set_i(2, 32767);
    repeat (4) begin
      sweep("spike", -1, 0, 0);
      check_all("spike");
    end
    repeat (6) begin
      for (int k = 0; k < N; k++) set_i(k, int'($urandom_range(0, 65535)) - 32768);
      sweep("rand", int'($urandom_range(0, N - 1)), int'($urandom_range(0, 20000)) - 4000, 0);
      check_all("rand");
    end
    chk("overrun sticky", bus.overrun_o, 1);
    @(negedge clk);
    bus.step_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.step_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst busy", bus.busy_o, 0);
    chk("midrst valid", bus.spike_valid_o, 0);
    chk("midrst overrun", bus.overrun_o, 0);
    chk("midrst spike", bus.spike_o, 0);
    chk("midrst mon_v", bus.mon_v_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.spike_valid_o) extra++;
    end
    chk("midrst no_valid", extra, 0);
    check_all("midrst");
    sweep("post_rst", -1, 0, 0);
    check_all("post_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/adex_neuron_mux.md
Name: adex_neuron_mux

Overview:
- Parametrised digital AdEx (adaptive exponential integrate-and-fire) neuron array for the tt_um_dpi_adexp tile.
- One shared fixed-point datapath is time-multiplexed over N_NEURONS state slots.
- Each step_i pulse runs one forward-Euler sweep over all neurons and reports the spike vector.
- Input currents are loaded through a write port; a monitor port exposes any neuron's state.

Parameters:
- N_NEURONS, 4, neuron count (power of 2, 2..16); AW = $clog2(N_NEURONS).
- V_W, 16, signed width of v, w and current I.
- E_L, -4096, leak reversal / reset value of v.
- V_T, -1024, exponential threshold.
- V_PEAK, 2048, spike detection level.
- V_RESET, -3072, post-spike v.
- B, 64, spike-triggered adaptation increment.
- LEAK_SH, 4; CUR_SH, 2; DELTA_SH, 8; A_SH, 6; TAUW_SH, 5: arithmetic right-shift time constants.
- EXP_CAP, 12, maximum exponent shift.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- step_i  in  1  single-cycle pulse; starts a sweep.
- i_we  in  1  current-register write enable.
- i_addr  in  AW  current-register index.
- i_data  in  V_W  signed input current.
- mon_sel  in  AW  neuron selected for monitoring.
- mon_v_o  out  V_W  registered v of mon_sel.
- mon_w_o  out  V_W  registered w of mon_sel.
- spike_o  out  N_NEURONS  spike vector of the last completed sweep.
- spike_valid_o  out  1  one-cycle pulse when spike_o updates.
- busy_o  out  1  sweep in progress.
- overrun_o  out  1  sticky flag: step_i arrived while busy.

Behaviour:
- Reset (async, rst_n=0), all immediate:
  - v[k]=E_L, w[k]=0, I[k]=0.
  - spike_o=0, spike_valid_o=0, busy_o=0, overrun_o=0, mon_*=0.
  - FSM to IDLE.
  - Reset mid-sweep aborts the sweep; no partial spike report.
- FSM states IDLE and SWEEP; index register idx.
  - IDLE + step_i: go to SWEEP, idx=0, busy_o=1 from the next edge.
  - SWEEP: one neuron is updated per cycle, idx = 0..N-1.
  - After idx=N-1: spike_o gets the accumulated vector, spike_valid_o=1 for one cycle, busy_o=0, return to IDLE.
  - Latency from step_i to spike_valid_o is N+1 cycles.
- step_i while busy: ignored, overrun_o set; it stays set until reset.
- Neuron update uses the old v and w (forward Euler). Intermediates are V_W+4 bits signed; results saturate to the signed V_W range.
  - leak = (E_L - v) >>> LEAK_SH
  - exp = (v >= V_T) ? (1 << min((v - V_T) >> DELTA_SH, EXP_CAP)) : 0
  - v' = sat(v + leak + exp + ((I - w) >>> CUR_SH))
  - w' = sat(w + ((((v - E_L) >>> A_SH) - w) >>> TAUW_SH))
  - If v' >= V_PEAK: store v=V_RESET, w=sat(w'+B), set the spike bit for that neuron.
  - Otherwise store v', w'.
- Write port: i_we writes I[i_addr] at the clock edge in any state.
  - If it targets the neuron updated in the same cycle, that update uses the old I.
- Monitor: mon_v_o/mon_w_o are registered every cycle from the selected slot (1-cycle latency). They show the post-write value the cycle after an update.

Optional Feature:
- Macro ADEX_REFRACTORY_EN.
- When defined:
  - Parameter REF_STEPS (default 2) and a per-neuron refractory counter (reset 0).
  - A spike loads the counter with REF_STEPS.
  - While the counter is nonzero, the sweep holds v=V_RESET, applies no integration and no spike, still updates w (w' rule, no B), and decrements the counter.
- When undefined: no counter logic; integration resumes on the sweep after the spike.

Decomposition:
- Package adex_pkg holds:
  - FSM state enum;
  - the default constants (E_L, V_T, V_PEAK, V_RESET, B, shifts);
  - a saturate function (wide signed in, V_W signed out).
- Sub-module adex_update: combinational single-neuron datapath (v, w, I, optional refractory count in; v', w', spike, count' out).
- Top holds the state registers, FSM and ports.

Test Plan:
- After reset, step with I=0 -> spike_valid_o pulses at cycle 5 (N=4); all v=-4096, w=0, spike_o=0.
- Write I[1]=400, step -> mon_sel=1 gives v=-3996, w=0; neurons 0, 2, 3 remain -4096.
- I[2]=32767, repeated steps -> spike_o[2]=1 on the first sweep with v'>=2048; that neuron then shows v=-3072 and w=prior w'+64; v never exceeds 32767.
- step_i asserted in cycle 2 of a sweep -> ignored, overrun_o=1, single spike_valid_o at cycle 5, states updated once.
- rst_n pulled low mid-sweep (idx=2) -> busy_o=0 immediately, no spike_valid_o, all states back to reset values.
- ADEX_REFRACTORY_EN, REF_STEPS=2, I[0]=32767 -> the two sweeps after a spike hold v=-3072 with spike_o[0]=0; integration resumes on the third.
